div_unit: RTL and testbench

Iterative RV32M divide/remainder unit in the execute stage. Consumes the two register-file read operands (A = dividend, B = divisor) and drives the register-file write port (write enable, destination select, write data) when a result is ready. Implements DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle. Results match RISC-V semantics for divide-by-zero and signed overflow.

---
 rtl/div_unit.sv | 132 +++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle.
// Latency: 33 cycles normal, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: start_i ignored while busy_o; flush_i aborts with no write.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opA_i,
    input  logic [31:0] opB_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        wen_o,
    output logic [4:0]  regW_sel_o,
    output logic [31:0] regW_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  sel_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [31:0] res_q;
    logic        qneg_q;
    logic        rneg_q;

    logic        accept;
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic        div_zero, ovf, special;
    logic [31:0] spec_res;

    logic [32:0] shifted, trial;
    logic        qbit;
    logic [31:0] rem_nxt, quo_nxt, rem_fin, quo_fin, calc_res;

    always_comb begin
        accept    = (state == IDLE) && start_i && !flush_i;
        signed_op = ~op_i[0];
        a_neg     = signed_op & opA_i[31];
        b_neg     = signed_op & opB_i[31];
        a_abs     = a_neg ? (~opA_i + 32'd1) : opA_i;
        b_abs     = b_neg ? (~opB_i + 32'd1) : opB_i;
        div_zero  = (opB_i == 32'd0);
        ovf       = signed_op && (opA_i == 32'h8000_0000) && (opB_i == 32'hFFFF_FFFF);
        special   = div_zero || ovf;
        if (div_zero)
            spec_res = op_i[1] ? opA_i : 32'hFFFF_FFFF;
        else
            spec_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // One restoring step: the 33-bit trial keeps the borrow as the sign.
    always_comb begin
        shifted  = {rem_q, dvd_q[31]};
        trial    = shifted - {1'b0, dvs_q};
        qbit     = ~trial[32];
        rem_nxt  = qbit ? trial[31:0] : shifted[31:0];
        quo_nxt  = {dvd_q[30:0], qbit};
        rem_fin  = rneg_q ? (~rem_nxt + 32'd1) : rem_nxt;
        quo_fin  = qneg_q ? (~quo_nxt + 32'd1) : quo_nxt;
        calc_res = op_q[1] ? rem_fin : quo_fin;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt_q == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= 2'd0;
            rd_q   <= 5'd0;
            sel_q  <= 5'd0;
            cnt_q  <= 5'd0;
            dvd_q  <= 32'd0;
            dvs_q  <= 32'd0;
            rem_q  <= 32'd0;
            res_q  <= 32'd0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= op_i;
                rd_q   <= rd_i;
                dvd_q  <= a_abs;
                dvs_q  <= b_abs;
                rem_q  <= 32'd0;
                cnt_q  <= 5'd31;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                if (special) begin
                    res_q <= spec_res;
                    sel_q <= rd_i;
                end
            end else if (state == CALC && !flush_i) begin
                rem_q <= rem_nxt;
                dvd_q <= quo_nxt;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    res_q <= calc_res;
                    sel_q <= rd_q;
                end
            end
        end
    end

    // Result/select registers only change on entry to DONE, so they hold otherwise.
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE) && !flush_i;
    assign wen_o      = done_o && (sel_q != 5'd0);
    assign regW_sel_o = sel_q;
    assign regW_o     = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: result, latency, busy length, write enable, abort paths.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opA_i;
    logic [31:0] opB_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic        wen_o;
    logic [4:0]  regW_sel_o;
    logic [31:0] regW_o;

    int n_cmp;
    int n_bad;

    div_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .opA_i      (opA_i),
        .opB_i      (opB_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wen_o      (wen_o),
        .regW_sel_o (regW_sel_o),
        .regW_o     (regW_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // ev_kind: 0 none, 1 extra start, 2 flush, 3 async reset
    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          ev_cyc;
        int          ev_kind;
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_ndone;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        int          lat;
        int          ndone;
        int          nbusy;
        logic [31:0] res;
        logic [4:0]  sel;
        logic        wen;
        lat   = -1;
        ndone = 0;
        nbusy = 0;
        res   = 32'd0;
        sel   = 5'd0;
        wen   = 1'b0;
        op_i    = v.op;
        opA_i   = v.a;
        opB_i   = v.b;
        rd_i    = v.rd;
        start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                start_i = 1'b0;
                opA_i   = 32'hDEAD_BEEF;
                opB_i   = 32'h0000_0001;
            end
            if (busy_o) nbusy++;
            if (done_o) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    res = regW_o;
                    sel = regW_sel_o;
                    wen = wen_o;
                end
            end
            if (v.ev_kind == 1 && c == v.ev_cyc) begin
                start_i = 1'b1;
                op_i    = OP_DIVU;
                opA_i   = 32'd9;
                opB_i   = 32'd3;
                rd_i    = 5'd7;
            end
            if (v.ev_kind == 1 && c == v.ev_cyc + 1) start_i = 1'b0;
            if (v.ev_kind == 2 && c == v.ev_cyc) flush_i = 1'b1;
            if (v.ev_kind == 2 && c == v.ev_cyc + 1) begin
                flush_i = 1'b0;
                check({v.name, " busy after flush"}, {31'd0, busy_o}, 32'd0);
            end
            if (v.ev_kind == 3 && c == v.ev_cyc) begin
                rst_n = 1'b0;
                #1;
                check({v.name, " rst busy"}, {31'd0, busy_o}, 32'd0);
                check({v.name, " rst done"}, {31'd0, done_o}, 32'd0);
                check({v.name, " rst wen"},  {31'd0, wen_o},  32'd0);
                check({v.name, " rst sel"},  {27'd0, regW_sel_o}, 32'd0);
                check({v.name, " rst data"}, regW_o, 32'd0);
            end
            if (v.ev_kind == 3 && c == v.ev_cyc + 1) rst_n = 1'b1;
        end
        check({v.name, " done count"}, ndone, v.exp_ndone);
        if (v.exp_ndone > 0) begin
            check({v.name, " result"},  res, v.exp_res);
            check({v.name, " latency"}, lat, v.exp_lat);
            check({v.name, " busy cycles"}, nbusy, v.exp_lat);
            check({v.name, " wen"}, {31'd0, wen}, {31'd0, v.exp_wen});
            check({v.name, " sel"}, {27'd0, sel}, {27'd0, v.rd});
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 2'b00;
        opA_i   = 32'd0;
        opB_i   = 32'd0;
        rd_i    = 5'd0;

        vecs.push_back('{"divu 100/7",     OP_DIVU, 32'd100,        32'd7,          5'd5,  0, 0, 32'd14,         33, 1, 1'b1});
        vecs.push_back('{"remu 100/7",     OP_REMU, 32'd100,        32'd7,          5'd6,  0, 0, 32'd2,          33, 1, 1'b1});
        vecs.push_back('{"div -7/2",       OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  0, 0, 32'hFFFF_FFFD,  33, 1, 1'b1});
        vecs.push_back('{"rem -7/2",       OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  0, 0, 32'hFFFF_FFFF,  33, 1, 1'b1});
        vecs.push_back('{"div 7/-2",       OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd3,  0, 0, 32'hFFFF_FFFD,  33, 1, 1'b1});
        vecs.push_back('{"rem 7/-2",       OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd4,  0, 0, 32'd1,          33, 1, 1'b1});
        vecs.push_back('{"divu max/1",     OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 0, 0, 32'hFFFF_FFFF,  33, 1, 1'b1});
        vecs.push_back('{"div 5/0",        OP_DIV,  32'd5,          32'd0,          5'd8,  0, 0, 32'hFFFF_FFFF,  1,  1, 1'b1});
        vecs.push_back('{"divu 5/0",       OP_DIVU, 32'd5,          32'd0,          5'd9,  0, 0, 32'hFFFF_FFFF,  1,  1, 1'b1});
        vecs.push_back('{"rem 5/0",        OP_REM,  32'd5,          32'd0,          5'd10, 0, 0, 32'd5,          1,  1, 1'b1});
        vecs.push_back('{"rem -5/0",       OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd11, 0, 0, 32'hFFFF_FFFB,  1,  1, 1'b1});
        vecs.push_back('{"div ovf",        OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 0, 0, 32'h8000_0000,  1,  1, 1'b1});
        vecs.push_back('{"rem ovf",        OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 0, 0, 32'd0,          1,  1, 1'b1});
        vecs.push_back('{"divu busy start",OP_DIVU, 32'd1000,       32'd3,          5'd14, 10, 1, 32'd333,       33, 1, 1'b1});
        vecs.push_back('{"divu flush",     OP_DIVU, 32'd1000,       32'd3,          5'd15, 20, 2, 32'd0,         0,  0, 1'b0});
        vecs.push_back('{"divu rd0",       OP_DIVU, 32'd9,          32'd3,          5'd0,  0, 0, 32'd3,          33, 1, 1'b0});
        vecs.push_back('{"div reset",      OP_DIV,  32'd1234,       32'd7,          5'd16, 15, 3, 32'd0,         0,  0, 1'b0});
        vecs.push_back('{"divu 50/5",      OP_DIVU, 32'd50,         32'd5,          5'd17, 0, 0, 32'd10,         33, 1, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset wen",  {31'd0, wen_o},  32'd0);
        check("reset sel",  {27'd0, regW_sel_o}, 32'd0);
        check("reset data", regW_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
